// File: rtl/vga_pkg.sv
// Shared definitions for the text console: grid defaults, control codes,
// FSM state encodings, cursor command set and the registered cell-write bundle.
package vga_pkg;

  localparam int DEF_COLS = 64;
  localparam int DEF_ROWS = 24;

  localparam logic [7:0] CC_BS    = 8'h08;
  localparam logic [7:0] CC_TAB   = 8'h09;
  localparam logic [7:0] CC_LF    = 8'h0A;
  localparam logic [7:0] CC_FF    = 8'h0C;
  localparam logic [7:0] CC_CR    = 8'h0D;
  localparam logic [7:0] CC_SPACE = 8'h20;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_CLEAR_LINE   = 2'd1;
  localparam logic [1:0] ST_CLEAR_SCREEN = 2'd2;

  typedef enum logic [2:0] {
    CUR_HOLD    = 3'd0,
    CUR_ADVANCE = 3'd1,
    CUR_NEWLINE = 3'd2,
    CUR_RETURN  = 3'd3,
    CUR_BACK    = 3'd4,
    CUR_TAB     = 3'd5,
    CUR_HOME    = 3'd6
  } cursorCmd_e;

  typedef struct packed {
    logic [23:0] fg;
    logic [23:0] bg;
    logic [7:0]  code;
    logic [5:0]  x;
    logic [4:0]  y;
  } cellWr_t;

  // Next multiple of 8 strictly above x; bit 6 lets callers detect overflow past the grid.
  function automatic logic [6:0] nextTabStop(input logic [5:0] x);
    return {1'b0, x[5:3], 3'b000} + 7'd8;
  endfunction

endpackage

// File: rtl/vga_console_cursor.sv
// Cursor position register: executes one command per cycle from the console FSM.
// Latency: position updates on the clock edge after the command; rowWrap is combinational.
// Backpressure: none, commands are always accepted.
module vga_console_cursor
  import vga_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [2:0] cmd,
  output logic       rowWrap,
  output logic [5:0] cursorX,
  output logic [4:0] cursorY
);

  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  logic [4:0] nextRow;
  logic [6:0] tabNext;
  logic       tabWrap;

  assign nextRow = (cursorY == LAST_ROW) ? 5'd0 : cursorY + 5'd1;
  assign tabNext = nextTabStop(cursorX);
  assign tabWrap = (tabNext >= 7'(COLS));

  // Tells the FSM that this command moves to a new row, which must then be blanked.
  always_comb begin
    rowWrap = 1'b0;
    case (cmd)
      CUR_ADVANCE: rowWrap = (cursorX == LAST_COL);
      CUR_NEWLINE: rowWrap = 1'b1;
      CUR_TAB:     rowWrap = tabWrap;
      default:     rowWrap = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cursorX <= 6'd0;
      cursorY <= 5'd0;
    end else begin
      case (cmd)
        CUR_ADVANCE: begin
          if (cursorX == LAST_COL) begin
            cursorX <= 6'd0;
            cursorY <= nextRow;
          end else begin
            cursorX <= cursorX + 6'd1;
          end
        end
        CUR_NEWLINE: begin
          cursorX <= 6'd0;
          cursorY <= nextRow;
        end
        CUR_RETURN: cursorX <= 6'd0;
        CUR_BACK: begin
          if (cursorX != 6'd0) cursorX <= cursorX - 6'd1;
        end
        CUR_TAB: begin
          if (tabWrap) begin
            cursorX <= 6'd0;
            cursorY <= nextRow;
          end else begin
            cursorX <= tabNext[5:0];
          end
        end
        CUR_HOME: begin
          cursorX <= 6'd0;
          cursorY <= 5'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vga_console.sv
// Text console front end: turns a byte stream into registered character-cell writes.
// Latency: one cycle from byte acceptance (or clear issue) to charWr; CONSOLE_TAB_EN enables tab stops.
// Backpressure: inReady drops for the whole of a line or screen clear.
module vga_console
  import vga_pkg::*;
#(
  parameter int          COLS   = DEF_COLS,
  parameter int          ROWS   = DEF_ROWS,
  parameter logic [23:0] DEF_FG = 24'hFFFFFF,
  parameter logic [23:0] DEF_BG = 24'h000000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        inValid,
  input  logic [7:0]  inCode,
  output logic        inReady,
  input  logic        colorWr,
  input  logic [23:0] colorFg,
  input  logic [23:0] colorBg,
  output logic        charWr,
  output logic [23:0] charWrFgColor,
  output logic [23:0] charWrBgColor,
  output logic [7:0]  charWrCode,
  output logic [5:0]  charWrX,
  output logic [4:0]  charWrY,
  output logic [5:0]  cursorX,
  output logic [4:0]  cursorY,
  output logic        busy
);

  logic [1:0]  state;
  logic [10:0] clrCnt;
  logic [23:0] fgColor;
  logic [23:0] bgColor;
  logic        accept;
  logic        rowWrap;
  logic        clrLast;
  logic        issue;
  logic [2:0]  curCmd;
  logic [5:0]  scrX;
  logic [4:0]  scrY;
  cellWr_t     issueCell;
  cellWr_t     wrCell;

  assign inReady = (state == ST_IDLE);
  assign busy    = (state != ST_IDLE);
  assign accept  = inValid && inReady;

  assign scrX = 6'(int'(clrCnt) % COLS);
  assign scrY = 5'(int'(clrCnt) / COLS);

  always_comb begin
    clrLast = 1'b0;
    case (state)
      ST_CLEAR_LINE:   clrLast = (clrCnt == 11'(COLS - 1));
      ST_CLEAR_SCREEN: clrLast = (clrCnt == 11'(COLS * ROWS - 1));
      default:         clrLast = 1'b0;
    endcase
  end

  // Byte decode and clear sequencing; the cell to write is taken from current colours.
  always_comb begin
    curCmd         = CUR_HOLD;
    issue          = 1'b0;
    issueCell.fg   = fgColor;
    issueCell.bg   = bgColor;
    issueCell.code = inCode;
    issueCell.x    = cursorX;
    issueCell.y    = cursorY;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (inCode)
            CC_LF: curCmd = CUR_NEWLINE;
            CC_CR: curCmd = CUR_RETURN;
            CC_BS: begin
              if (cursorX != 6'd0) begin
                curCmd         = CUR_BACK;
                issue          = 1'b1;
                issueCell.code = CC_SPACE;
                issueCell.x    = cursorX - 6'd1;
              end
            end
            CC_FF: curCmd = CUR_HOLD;
`ifdef CONSOLE_TAB_EN
            CC_TAB: curCmd = CUR_TAB;
`endif
            default: begin
              curCmd = CUR_ADVANCE;
              issue  = 1'b1;
            end
          endcase
        end
      end
      ST_CLEAR_LINE: begin
        issue          = 1'b1;
        issueCell.code = CC_SPACE;
        issueCell.x    = clrCnt[5:0];
      end
      ST_CLEAR_SCREEN: begin
        issue          = 1'b1;
        issueCell.code = CC_SPACE;
        issueCell.x    = scrX;
        issueCell.y    = scrY;
        if (clrLast) curCmd = CUR_HOME;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state   <= ST_IDLE;
      clrCnt  <= 11'd0;
      fgColor <= DEF_FG;
      bgColor <= DEF_BG;
      charWr  <= 1'b0;
      wrCell  <= '0;
    end else begin
      charWr <= issue;
      if (issue) wrCell <= issueCell;
      // Colour load lands after this cycle's issue, so the issued cell keeps the old colours.
      if (colorWr) begin
        fgColor <= colorFg;
        bgColor <= colorBg;
      end
      case (state)
        ST_IDLE: begin
          clrCnt <= 11'd0;
          if (accept && inCode == CC_FF) state <= ST_CLEAR_SCREEN;
          else if (rowWrap)              state <= ST_CLEAR_LINE;
        end
        ST_CLEAR_LINE, ST_CLEAR_SCREEN: begin
          if (clrLast) begin
            state  <= ST_IDLE;
            clrCnt <= 11'd0;
          end else begin
            clrCnt <= clrCnt + 11'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign charWrFgColor = wrCell.fg;
  assign charWrBgColor = wrCell.bg;
  assign charWrCode    = wrCell.code;
  assign charWrX       = wrCell.x;
  assign charWrY       = wrCell.y;

  vga_console_cursor #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) uCursor (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .cmd     (curCmd),
    .rowWrap (rowWrap),
    .cursorX (cursorX),
    .cursorY (cursorY)
  );

endmodule

// File: tb/tb_vga_console.sv
// Bench for vga_console: a queue-based console model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vga_console;

  localparam int COLS = 64;
  localparam int ROWS = 24;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b1;
  logic        inValid  = 1'b0;
  logic [7:0]  inCode   = 8'h00;
  logic        colorWr  = 1'b0;
  logic [23:0] colorFg  = 24'h0;
  logic [23:0] colorBg  = 24'h0;
  logic        inReady;
  logic        charWr;
  logic [23:0] charWrFgColor;
  logic [23:0] charWrBgColor;
  logic [7:0]  charWrCode;
  logic [5:0]  charWrX;
  logic [4:0]  charWrY;
  logic [5:0]  cursorX;
  logic [4:0]  cursorY;
  logic        busy;

  vga_console dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .inValid      (inValid),
    .inCode       (inCode),
    .inReady      (inReady),
    .colorWr      (colorWr),
    .colorFg      (colorFg),
    .colorBg      (colorBg),
    .charWr       (charWr),
    .charWrFgColor(charWrFgColor),
    .charWrBgColor(charWrBgColor),
    .charWrCode   (charWrCode),
    .charWrX      (charWrX),
    .charWrY      (charWrY),
    .cursorX      (cursorX),
    .cursorY      (cursorY),
    .busy         (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int nCmp = 0;
  int nBad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [5:0] x;
    logic [4:0] y;
  } pos_t;

  pos_t        clrQ[$];
  bit          clrScreen = 1'b0;
  int          mx = 0, my = 0;
  logic [23:0] mfg = 24'hFFFFFF, mbg = 24'h000000;
  bit          eWr = 1'b0;
  logic [7:0]  eCode = 8'h0;
  int          eX = 0, eY = 0;
  logic [23:0] eFg = 24'h0, eBg = 24'h0;

  task automatic emit(input logic [7:0] code, input int x, input int y);
    eWr = 1'b1; eCode = code; eX = x; eY = y; eFg = mfg; eBg = mbg;
  endtask

  task automatic rowAdvance();
    pos_t p;
    my = (my == ROWS - 1) ? 0 : my + 1;
    for (int c = 0; c < COLS; c++) begin
      p.x = 6'(c); p.y = 5'(my);
      clrQ.push_back(p);
    end
    clrScreen = 1'b0;
  endtask

  task automatic modelStep();
    pos_t p;
    if (reset) begin
      mx = 0; my = 0; mfg = 24'hFFFFFF; mbg = 24'h000000;
      clrQ.delete(); clrScreen = 1'b0; eWr = 1'b0;
    end else begin
      eWr = 1'b0;
      if (clrQ.size() != 0) begin
        p = clrQ.pop_front();
        emit(8'h20, int'(p.x), int'(p.y));
        if (clrQ.size() == 0 && clrScreen) begin mx = 0; my = 0; end
      end else if (inValid) begin
        if (inCode == 8'h0A) begin
          mx = 0; rowAdvance();
        end else if (inCode == 8'h0D) begin
          mx = 0;
        end else if (inCode == 8'h08) begin
          if (mx > 0) begin mx = mx - 1; emit(8'h20, mx, my); end
        end else if (inCode == 8'h0C) begin
          for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) begin
              p.x = 6'(x); p.y = 5'(y);
              clrQ.push_back(p);
            end
          clrScreen = 1'b1;
`ifdef CONSOLE_TAB_EN
        end else if (inCode == 8'h09) begin
          if ((mx / 8 + 1) * 8 >= COLS) begin mx = 0; rowAdvance(); end
          else mx = (mx / 8 + 1) * 8;
`endif
        end else begin
          emit(inCode, mx, my);
          if (mx == COLS - 1) begin mx = 0; rowAdvance(); end
          else mx = mx + 1;
        end
      end
      if (colorWr) begin mfg = colorFg; mbg = colorBg; end
    end
  endtask

  // Model advances on each edge; outputs are compared just after it.
  always @(posedge CLOCK_50) begin
    modelStep();
    #1;
    chk("inReady", 32'(inReady), 32'(clrQ.size() == 0));
    chk("busy",    32'(busy),    32'(clrQ.size() != 0));
    chk("cursorX", 32'(cursorX), 32'(mx));
    chk("cursorY", 32'(cursorY), 32'(my));
    chk("charWr",  32'(charWr),  32'(eWr));
    if (eWr) begin
      chk("charWrCode", 32'(charWrCode), 32'(eCode));
      chk("charWrX",    32'(charWrX),    32'(eX));
      chk("charWrY",    32'(charWrY),    32'(eY));
      chk("charWrFg",   32'(charWrFgColor), 32'(eFg));
      chk("charWrBg",   32'(charWrBgColor), 32'(eBg));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic sendByte(input logic [7:0] c);
    int guard = 0;
    @(negedge CLOCK_50);
    inValid = 1'b1; inCode = c;
    while (!inReady && guard < 3000) begin
      @(negedge CLOCK_50);
      guard++;
    end
    if (guard >= 3000) chk("sendTimeout", 32'(inReady), 32'd1);
    @(posedge CLOCK_50); #1;
    inValid = 1'b0;
  endtask

  // Counts pulses until inReady returns; bounded so a stuck DUT still ends.
  task automatic countPulses(output int n, output int fx, output int fy, output int lx, output int ly);
    int guard = 0;
    n = 0; fx = -1; fy = -1; lx = -1; ly = -1;
    while (guard < 2000) begin
      @(posedge CLOCK_50); #1;
      guard++;
      if (charWr && charWrCode == 8'h20) begin
        if (n == 0) begin fx = int'(charWrX); fy = int'(charWrY); end
        lx = int'(charWrX); ly = int'(charWrY);
        n++;
      end
      if (inReady) break;
    end
    if (guard >= 2000) chk("clearTimeout", 32'(inReady), 32'd1);
  endtask

  initial begin
    int n, fx, fy, lx, ly;
    int r;
    logic [7:0] c;

    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
    chk("rst_charWr",  32'(charWr), 32'd0);
    chk("rst_code",    32'(charWrCode), 32'd0);
    chk("rst_wrX",     32'(charWrX), 32'd0);
    chk("rst_wrFg",    32'(charWrFgColor), 32'd0);
    chk("rst_inReady", 32'(inReady), 32'd1);
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_cursor",  32'({cursorX, cursorY}), 32'd0);

    // Single printable character
    sendByte(8'h41);
    chk("A_charWr", 32'(charWr), 32'd1);
    chk("A_code",   32'(charWrCode), 32'h41);
    chk("A_xy",     32'({charWrX, charWrY}), 32'd0);
    chk("A_fg",     32'(charWrFgColor), 32'hFFFFFF);
    chk("A_bg",     32'(charWrBgColor), 32'h000000);
    chk("A_curX",   32'(cursorX), 32'd1);

    // Fill row 0, wrap into row 1 and watch its clear
    for (int i = 0; i < 63; i++) sendByte(8'h61 + 8'(i % 26));
    chk("wrap_lastX",   32'(charWrX), 32'd63);
    chk("wrap_lastY",   32'(charWrY), 32'd0);
    chk("wrap_cursor",  32'({cursorX, cursorY}), 32'({6'd0, 5'd1}));
    chk("wrap_inReady", 32'(inReady), 32'd0);
    countPulses(n, fx, fy, lx, ly);
    chk("line_pulses", 32'(n), 32'd64);
    chk("line_first",  32'(fx), 32'd0);
    chk("line_last",   32'(lx), 32'd63);
    chk("line_row",    32'(ly), 32'd1);

    // Row wrap from the bottom of the grid
    for (int i = 0; i < 22; i++) sendByte(8'h0A);
    countPulses(n, fx, fy, lx, ly);
    chk("bottom_row", 32'(cursorY), 32'd23);
    sendByte(8'h0A);
    chk("lf_cursor", 32'({cursorX, cursorY}), 32'd0);
    countPulses(n, fx, fy, lx, ly);
    chk("lf_pulses", 32'(n), 32'd64);
    chk("lf_row",    32'(fy), 32'd0);
    chk("lf_last",   32'(lx), 32'd63);

    // Backspace, including at column 0
    sendByte(8'h0A);
    sendByte(8'h0A);
    for (int i = 0; i < 5; i++) sendByte(8'h78);
    chk("bs_pre", 32'({cursorX, cursorY}), 32'({6'd5, 5'd2}));
    sendByte(8'h08);
    chk("bs_charWr", 32'(charWr), 32'd1);
    chk("bs_code",   32'(charWrCode), 32'h20);
    chk("bs_xy",     32'({charWrX, charWrY}), 32'({6'd4, 5'd2}));
    chk("bs_cursor", 32'(cursorX), 32'd4);
    sendByte(8'h0D);
    sendByte(8'h08);
    chk("bs0_charWr", 32'(charWr), 32'd0);
    chk("bs0_cursor", 32'({cursorX, cursorY}), 32'({6'd0, 5'd2}));

    // Colour change coincident with a byte
    @(negedge CLOCK_50);
    inValid = 1'b1; inCode = 8'h42;
    colorWr = 1'b1; colorFg = 24'hFF0000; colorBg = 24'h0000FF;
    @(posedge CLOCK_50); #1;
    inValid = 1'b0; colorWr = 1'b0;
    chk("B_code", 32'(charWrCode), 32'h42);
    chk("B_fg",   32'(charWrFgColor), 32'hFFFFFF);
    chk("B_bg",   32'(charWrBgColor), 32'h000000);
    sendByte(8'h43);
    chk("C_code", 32'(charWrCode), 32'h43);
    chk("C_fg",   32'(charWrFgColor), 32'hFF0000);
    chk("C_bg",   32'(charWrBgColor), 32'h0000FF);

    // Tab
    sendByte(8'h0D);
    for (int i = 0; i < 3; i++) sendByte(8'h31);
    sendByte(8'h09);
`ifdef CONSOLE_TAB_EN
    chk("tab_charWr", 32'(charWr), 32'd0);
    chk("tab_cursor", 32'(cursorX), 32'd8);
`else
    chk("tab_charWr", 32'(charWr), 32'd1);
    chk("tab_code",   32'(charWrCode), 32'h09);
    chk("tab_cursor", 32'(cursorX), 32'd4);
`endif

    // Full screen clear
    sendByte(8'h0C);
    chk("ff_inReady", 32'(inReady), 32'd0);
    countPulses(n, fx, fy, lx, ly);
    chk("ff_pulses", 32'(n), 32'd1536);
    chk("ff_first",  32'({fx[5:0], fy[4:0]}), 32'd0);
    chk("ff_last",   32'({lx[5:0], ly[4:0]}), 32'({6'd63, 5'd23}));
    chk("ff_cursor", 32'({cursorX, cursorY}), 32'd0);

    // Screen clear aborted by reset at pulse 700
    sendByte(8'h37);
    sendByte(8'h0C);
    n = 0;
    for (int g = 0; g < 2000 && n < 700; g++) begin
      @(posedge CLOCK_50); #1;
      if (charWr) n++;
    end
    chk("abort_reached", 32'(n), 32'd700);
    reset = 1'b1;
    @(posedge CLOCK_50); #1;
    chk("abort_charWr",  32'(charWr), 32'd0);
    chk("abort_inReady", 32'(inReady), 32'd1);
    chk("abort_cursor",  32'({cursorX, cursorY}), 32'd0);
    @(negedge CLOCK_50);
    reset = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      @(negedge CLOCK_50);
      reset   = (i == 3000);
      inValid = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 99);
      c = 8'($urandom_range(0, 255));
      if (c == 8'h0C) c = 8'h41;
      if (r < 8)       c = 8'h0A;
      else if (r < 13) c = 8'h0D;
      else if (r < 22) c = 8'h08;
      else if (r < 27) c = 8'h09;
      else if (r == 99 && $urandom_range(0, 9) == 0) c = 8'h0C;
      inCode  = c;
      colorWr = ($urandom_range(0, 15) == 0);
      colorFg = 24'($urandom);
      colorBg = 24'($urandom);
    end
    @(negedge CLOCK_50);
    inValid = 1'b0; colorWr = 1'b0; reset = 1'b0;
    repeat (4) @(negedge CLOCK_50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/vga_console.md
Name: vga_console

Overview:
- Text-mode console front end that sits directly upstream of the VGA character display.
- Accepts a byte stream from the CPU/peripheral bus through a valid/ready handshake.
- Tracks a cursor on the 64x24 character grid (640x480, 10x20 glyphs) and interprets control codes.
- Drives the display's character write port (charWr, fg/bg colour, code, X, Y) with one registered write per cycle.

Parameters:
- COLS, 64, grid columns; charWrX width stays 6 bits.
- ROWS, 24, grid rows; charWrY width stays 5 bits.
- DEF_FG, 24'hFFFFFF, foreground colour after reset.
- DEF_BG, 24'h000000, background colour after reset.

Ports:
- CLOCK_50  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- inValid  in  1  inCode is valid.
- inCode  in  8  character or control byte.
- inReady  out  1  console can accept a byte this cycle.
- colorWr  in  1  strobe: load colorFg/colorBg.
- colorFg  in  24  new foreground colour.
- colorBg  in  24  new background colour.
- charWr  out  1  write strobe to the display.
- charWrFgColor  out  24  foreground colour of the written cell.
- charWrBgColor  out  24  background colour of the written cell.
- charWrCode  out  8  glyph code of the written cell.
- charWrX  out  6  cell column.
- charWrY  out  5  cell row.
- cursorX  out  6  current cursor column.
- cursorY  out  5  current cursor row.
- busy  out  1  a clear operation is in progress.

Behaviour:
- Reset:
  - charWr=0, charWrCode=0, charWrX=0, charWrY=0, charWrFg/BgColor=0.
  - cursor=(0,0); fg=DEF_FG, bg=DEF_BG; state IDLE; inReady=1; busy=0.
  - Reset in any state aborts the operation immediately. No automatic clear on reset.
- Handshake:
  - inReady = (state==IDLE), combinational from state only.
  - A byte is accepted when inValid && inReady. Holding inValid while inReady=0 has no effect.
- All write outputs are registered: a byte accepted in cycle N appears on charWr in cycle N+1 (1-cycle latency). charWr is a single-cycle pulse per cell.
- States: IDLE, CLEAR_LINE, CLEAR_SCREEN.
- Printable byte (any code not listed below):
  - Write the code at the cursor with current fg/bg, then advance cursorX.
  - If cursorX==COLS-1: cursorX<=0 and the row advances.
- Row advance:
  - cursorY<=(cursorY==ROWS-1) ? 0 : cursorY+1. No scrolling; the grid wraps to row 0.
  - Then enter CLEAR_LINE for the new row.
- 0x0A LF: cursorX<=0, row advance (enters CLEAR_LINE). No cell write.
- 0x0D CR: cursorX<=0. No write.
- 0x08 BS:
  - If cursorX>0: cursorX<=cursorX-1 and write 0x20 at the new position.
  - If cursorX==0: no-op, no write, no wrap to the previous row.
- 0x0C FF: enter CLEAR_SCREEN.
- CLEAR_LINE:
  - Writes 0x20 with current colours to columns 0..COLS-1 of cursorY, one per cycle, ascending. That is COLS consecutive charWr pulses.
  - Returns to IDLE the cycle after the last issue.
  - busy=1 throughout.
- CLEAR_SCREEN:
  - Writes 0x20 to all COLS*ROWS cells in row-major order, one per cycle (1536 pulses by default).
  - On completion: cursor=(0,0), IDLE.
- Colour updates:
  - colorWr is honoured in any state; new colours apply from the next cycle.
  - A byte accepted in the same cycle as colorWr uses the old colours.
  - A clear in progress picks up the new colours for its remaining cells.
- Counter widths: the clear counter is 11 bits. X/Y never exceed COLS-1/ROWS-1.

Optional Feature:
- CONSOLE_TAB_EN defined: 0x09 advances cursorX to the next multiple of 8 without writing cells.
  - From column 56..63 it moves to column 0 and performs a row advance.
- CONSOLE_TAB_EN undefined: 0x09 is treated as a printable byte (written as glyph 9).

Decomposition:
- Shared package vga_pkg:
  - COLS/ROWS defaults.
  - Control code constants (CC_LF=8'h0A, CC_CR=8'h0D, CC_BS=8'h08, CC_FF=8'h0C, CC_TAB=8'h09, CC_SPACE=8'h20).
  - Console state enum.
- Sub-module vga_console_cursor: holds cursorX/Y, implements advance/wrap/row-advance/backspace. The top-level FSM drives its command inputs.

Test Plan:
- Reset, then send 'A'(0x41) with inValid=1: one cycle later charWr=1, code=0x41, X=0, Y=0, fg=FFFFFF, bg=000000; cursor=(1,0).
- Send 64 printable bytes from (0,0): the last write is at X=63, Y=0; cursor=(0,1); then 64 clear pulses on Y=1 with inReady=0; inReady returns to 1 after the 64th.
- Cursor at (0,23), send 0x0A: cursor=(0,0); 64 clear pulses at Y=0, X=0..63.
- Cursor at (5,2), send 0x08: write 0x20 at (4,2), cursor=(4,2); at (0,2) send 0x08: no charWr, cursor unchanged.
- Send 0x0C: exactly 1536 charWr pulses, first at (0,0), last at (63,23); inReady=0 throughout; assert reset at pulse 700 -> charWr=0 next cycle, inReady=1, cursor=(0,0).
- colorWr with fg=FF0000, bg=0000FF in the same cycle as accepting 'B': 'B' is written with the old colours; the next byte 'C' is written with FF0000/0000FF. With CONSOLE_TAB_EN, 0x09 at X=3 moves cursor to X=8 with no write.
